water_reminder_sched: RTL
=========================

# water_reminder_sched

Reminder scheduler for the water-reminder design. It builds the emulated-time base from a phase accumulator with a selectable speed-up (1x, 60x, 3600x, paused) and emits one-cycle second ticks. It runs the reminder countdown state machine that raises `alert` when the drink interval expires, and handles acknowledge and snooze. It sits between the 50 MHz board clock and the display/buzzer logic, and replaces the free-running divided clocks with single-clock tick enables.

## Interface
- `ACC_W`, 40: phase-accumulator width.
- `INC_1X`, 21990: increment for real time (1 emulated second per real second at 50 MHz).
- `INC_60X`, 1319414: increment for 1 real second = 1 emulated minute.
- `INC_3600X`, 79164837: increment for 1 real second = 1 emulated hour.
- `SNOOZE_SEC`, 300: snooze length in emulated seconds.
- `MISS_SEC`, 600: unacknowledged-alert time that counts as a missed reminder.

Ports:
- `clk` in 1: system clock, 50 MHz nominal.
- `reset` in 1: asynchronous, active-low reset.
- `rate_sel` in 2: 0=1x, 1=60x, 2=3600x, 3=paused.
- `interval` in 16: reminder interval in emulated seconds; sampled on load.
- `start` in 1: one-cycle pulse; arm or restart the countdown.
- `stop` in 1: one-cycle pulse; return to IDLE.
- `ack` in 1: one-cycle pulse; user drank; rearm.
- `snooze` in 1: one-cycle pulse; postpone alert.
- `sec_tick` out 1: one-cycle pulse per emulated second.
- `remaining` out 16: emulated seconds left in the current countdown.
- `state` out 2: 0=IDLE, 1=COUNT, 2=ALERT, 3=SNOOZE.
- `alert` out 1: high while in ALERT.
- `missed_cnt` out 8: count of missed reminders (see Configuration).

## Operation
- Accumulator: each cycle `acc <= acc + inc(rate_sel)`, modulo 2^ACC_W. When `rate_sel`=3, `acc` holds and no ticks are produced.
- Rate change: the new increment takes effect on the next cycle. `acc` is never cleared by a rate change.
- `sec_tick` is registered. It is 1 in the cycle in which `acc[ACC_W-1]` becomes 1, i.e. the old MSB was 0 and the new MSB is 1. Maximum one tick per 2 cycles.
- Command priority, evaluated each cycle: `stop` > `start` > `ack` > `snooze` > tick.
- IDLE:
  - `remaining`=0.
  - `start` loads `remaining`=`interval` and goes to COUNT.
  - If `interval`=0, `start` goes straight to ALERT.
- COUNT:
  - Each `sec_tick` decrements `remaining`.
  - A tick with `remaining`=1 sets `remaining`=0 and goes to ALERT.
  - `start` reloads `interval`.
  - `ack` and `snooze` are ignored.
- ALERT:
  - `alert`=1 and `remaining`=0.
  - `ack` reloads `interval` and goes to COUNT, or to ALERT again if `interval`=0.
  - `snooze` loads `SNOOZE_SEC` and goes to SNOOZE.
- SNOOZE:
  - Counts down exactly as COUNT does, then goes to ALERT.
  - `ack` reloads `interval` and goes to COUNT.
  - A repeated `snooze` reloads `SNOOZE_SEC`.
- `stop` in any state: go to IDLE, `remaining`=0, `alert`=0. The accumulator keeps running.
- `remaining` never wraps below 0.

## Timing
- Reset values:
  - `acc`=0, `sec_tick`=0, `state`=IDLE.
  - `remaining`=0, `alert`=0, `missed_cnt`=0.
- Reset asserted mid-countdown returns all outputs to their reset values immediately (asynchronous).
- All outputs are registered.
- Command latency: a command pulse in cycle n is reflected in `state`, `remaining` and `alert` at cycle n+1.
- Tick latency: a tick in cycle n updates `remaining` at cycle n+1.
- Tick period is 2^ACC_W/inc cycles, with ±1 cycle jitter (phase-accumulator behaviour). At defaults, 1x gives about 50,000,530 cycles per tick.
- A command coinciding with a tick: the command wins and that tick's decrement is dropped.

## Configuration
- `REMINDER_MISSED_CNT_EN` defined:
  - An internal ALERT-duration counter counts ticks spent in ALERT. It is cleared on every entry to ALERT.
  - When it reaches `MISS_SEC`, `missed_cnt` increments once per ALERT episode.
  - `missed_cnt` saturates at 255 and is cleared only by reset.
- `REMINDER_MISSED_CNT_EN` undefined:
  - No ALERT-duration counter is built.
  - `missed_cnt` is tied to 0; the port remains, so the interface is unchanged.

## Test plan
Unless stated otherwise, the bench overrides `ACC_W`=8, `INC_1X`=16, `INC_60X`=32, `INC_3600X`=64, `SNOOZE_SEC`=3, `MISS_SEC`=4.

1. Tick rates. `rate_sel`=0, 1, 2 in turn -> tick every 16, 8, 4 cycles respectively. `rate_sel`=3 -> no ticks, and `acc` holds its value.
2. Countdown to alert. `interval`=5, pulse `start` -> `remaining` steps 5,4,3,2,1,0 on consecutive ticks. `state`=ALERT and `alert`=1 one cycle after the fifth tick.
3. Snooze then ack. In ALERT, pulse `snooze` -> SNOOZE with `remaining`=3; three ticks later -> ALERT. Then pulse `ack` -> COUNT with `remaining`=`interval`.
4. Simultaneous commands. `stop` and `start` in the same cycle -> IDLE. `ack` and `snooze` in ALERT -> COUNT. A `start` coinciding with a tick in COUNT -> `remaining`=`interval`, no decrement.
5. Edge values:
   - `interval`=0 with `start` -> ALERT next cycle.
   - `reset` low mid-count -> all outputs 0 and `state`=IDLE immediately.
6. Missed-reminder counter:
   - With `REMINDER_MISSED_CNT_EN`: stay in ALERT for 4 ticks -> `missed_cnt`=1, with no further increment in that ALERT episode.
   - Without `REMINDER_MISSED_CNT_EN`: `missed_cnt` stays 0.

Source files
------------

// File: rtl/water_reminder_sched.sv
// Reminder scheduler: phase-accumulator emulated-second tick plus countdown/alert/snooze FSM.
// Optional missed-reminder counter is built when REMINDER_MISSED_CNT_EN is defined.
module water_reminder_sched #(
    parameter int unsigned     ACC_W      = 40,
    parameter longint unsigned INC_1X     = 21990,
    parameter longint unsigned INC_60X    = 1319414,
    parameter longint unsigned INC_3600X  = 79164837,
    parameter int unsigned     SNOOZE_SEC = 300,
    parameter int unsigned     MISS_SEC   = 600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rate_sel,
    input  logic [15:0] interval,
    input  logic        start,
    input  logic        stop,
    input  logic        ack,
    input  logic        snooze,
    output logic        sec_tick,
    output logic [15:0] remaining,
    output logic [1:0]  state,
    output logic        alert,
    output logic [7:0]  missed_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ALERT  = 2'd2,
        SNOOZE = 2'd3
    } state_t;

    state_t           st;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] acc_next;

    always_comb begin
        case (rate_sel)
            2'd0:    inc = ACC_W'(INC_1X);
            2'd1:    inc = ACC_W'(INC_60X);
            2'd2:    inc = ACC_W'(INC_3600X);
            default: inc = '0;
        endcase
    end

    assign acc_next = acc + inc;

    // A tick marks the MSB rising; a zero increment can never produce one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            sec_tick <= 1'b0;
        end else begin
            acc      <= acc_next;
            sec_tick <= ~acc[ACC_W-1] & acc_next[ACC_W-1];
        end
    end

    assign state = st;

`ifdef REMINDER_MISSED_CNT_EN
    logic [15:0] alert_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            remaining <= '0;
            alert     <= 1'b0;
`ifdef REMINDER_MISSED_CNT_EN
            alert_cnt  <= '0;
            missed_cnt <= '0;
`endif
        end else begin
`ifdef REMINDER_MISSED_CNT_EN
            // Cleared everywhere except while resting in ALERT, so every entry starts at 0.
            alert_cnt <= '0;
`endif
            if (stop) begin
                st        <= IDLE;
                remaining <= '0;
                alert     <= 1'b0;
            end else if (start || (ack && (st == ALERT || st == SNOOZE))) begin
                if (interval == 16'd0) begin
                    st        <= ALERT;
                    remaining <= '0;
                    alert     <= 1'b1;
                end else begin
                    st        <= COUNT;
                    remaining <= interval;
                    alert     <= 1'b0;
                end
            end else if (snooze && (st == ALERT || st == SNOOZE)) begin
                st        <= SNOOZE;
                remaining <= 16'(SNOOZE_SEC);
                alert     <= 1'b0;
            end else begin
                case (st)
                    COUNT, SNOOZE: begin
                        if (sec_tick) begin
                            if (remaining <= 16'd1) begin
                                st        <= ALERT;
                                remaining <= '0;
                                alert     <= 1'b1;
                            end else begin
                                remaining <= remaining - 16'd1;
                            end
                        end
                    end
                    ALERT: begin
`ifdef REMINDER_MISSED_CNT_EN
                        // Counter parks at MISS_SEC so the episode is counted only once.
                        alert_cnt <= alert_cnt;
                        if (sec_tick && alert_cnt != 16'(MISS_SEC)) begin
                            alert_cnt <= alert_cnt + 16'd1;
                            if (alert_cnt == 16'(MISS_SEC - 1) && missed_cnt != 8'hFF)
                                missed_cnt <= missed_cnt + 8'd1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

`ifndef REMINDER_MISSED_CNT_EN
    assign missed_cnt = '0;
`endif

endmodule
